// File: rtl/ahb_arbiter_rr_pkg.sv
// Shared AHB bus encodings and beat-count helper for the round-robin arbiter.
// HTRANS/HBURST/HRESP values are defined here once and imported everywhere else.
package ahb_arbiter_rr_pkg;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'b00,
      HTRANS_BUSY   = 2'b01,
      HTRANS_NONSEQ = 2'b10,
      HTRANS_SEQ    = 2'b11
   } htrans_e;

   typedef enum logic [2:0] {
      HBURST_SINGLE = 3'b000,
      HBURST_INCR   = 3'b001,
      HBURST_WRAP4  = 3'b010,
      HBURST_INCR4  = 3'b011,
      HBURST_WRAP8  = 3'b100,
      HBURST_INCR8  = 3'b101,
      HBURST_WRAP16 = 3'b110,
      HBURST_INCR16 = 3'b111
   } hburst_e;

   typedef enum logic [1:0] {
      HRESP_OKAY  = 2'b00,
      HRESP_ERROR = 2'b01,
      HRESP_RETRY = 2'b10,
      HRESP_SPLIT = 2'b11
   } hresp_e;

   localparam int CNT_W = 4;

   // Beats still to come after the NONSEQ beat of a burst of the given type.
   function automatic logic [CNT_W-1:0] burst_remaining(input logic [2:0] hburst,
                                                        input int       incr_max_beats);
      case (hburst)
         HBURST_SINGLE:                 return CNT_W'(0);
         HBURST_INCR:                   return CNT_W'(incr_max_beats - 1);
         HBURST_WRAP4,  HBURST_INCR4:   return CNT_W'(3);
         HBURST_WRAP8,  HBURST_INCR8:   return CNT_W'(7);
         default:                       return CNT_W'(15);
      endcase
   endfunction

endpackage

// File: rtl/ahb_rr_pick.sv
// Combinational round-robin picker: first requester found cyclically after ptr.
// valid is low when nobody requests; idx is then meaningless.
module ahb_rr_pick
   import ahb_arbiter_rr_pkg::*;
#(
   parameter int N_MASTER = 4,
   parameter int W_MASTER = 2
) (
   input  logic [N_MASTER-1:0] req,
   input  logic [W_MASTER-1:0] ptr,
   output logic [W_MASTER-1:0] idx,
   output logic                valid
);

   int cand;

   always_comb begin
      // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
      idx   = '0;
      valid = 1'b0;
      cand  = 0;
      // Walk from the farthest offset down so the nearest requester is written last and wins.
      for (int off = N_MASTER; off >= 1; off--) begin
         cand = int'(ptr) + off;
         if (cand >= N_MASTER) cand = cand - N_MASTER;
         if (cand < N_MASTER && req[cand]) begin
            idx   = W_MASTER'(cand);
            valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/ahb_arbiter_rr.sv
// AHB round-robin bus arbiter with burst-aware handover, locked tenures and an
// INCR tenure limit. All outputs are registered and move only on accepted beats.
module ahb_arbiter_rr
   import ahb_arbiter_rr_pkg::*;
#(
   parameter int N_MASTER       = 4,
   parameter int W_MASTER       = 2,
   parameter int DEF_MASTER     = 0,
   parameter int INCR_MAX_BEATS = 16
) (
   input  logic                HCLK,
   input  logic                HRESETn,
   input  logic [N_MASTER-1:0] HBUSREQ,
   input  logic [N_MASTER-1:0] HLOCK,
   input  logic [1:0]          HTRANS,
   input  logic [2:0]          HBURST,
   input  logic                HREADY,
   output logic [N_MASTER-1:0] HGRANT,
   output logic [W_MASTER-1:0] HMASTER,
   output logic                HMASTLOCK
);

   localparam logic [W_MASTER-1:0] DEF_IDX   = W_MASTER'(DEF_MASTER);
   localparam logic [N_MASTER-1:0] DEF_GRANT = N_MASTER'(1) << DEF_MASTER;

   logic [CNT_W-1:0]    cnt;
   logic [CNT_W-1:0]    cnt_next;
   logic [W_MASTER-1:0] rr_ptr;
   logic [W_MASTER-1:0] gnt_idx;
   logic [W_MASTER-1:0] pick_idx;
   logic                pick_valid;
   logic                winner_from_req;
   logic [W_MASTER-1:0] winner;
   logic                arb_point;

   ahb_rr_pick #(
      .N_MASTER (N_MASTER),
      .W_MASTER (W_MASTER)
   ) u_pick (
      .req   (HBUSREQ),
      .ptr   (rr_ptr),
      .idx   (pick_idx),
      .valid (pick_valid)
   );

   // An out-of-range pick can only come from a bad pointer; park on the default master.
   assign winner_from_req = pick_valid && (int'(pick_idx) < N_MASTER);
   assign winner          = winner_from_req ? pick_idx : DEF_IDX;

   always_comb begin
      arb_point = 1'b0;
      cnt_next  = cnt;
      case (HTRANS)
         HTRANS_IDLE: begin
            arb_point = 1'b1;
            cnt_next  = '0;
         end
         HTRANS_NONSEQ: begin
            arb_point = (HBURST == HBURST_SINGLE);
            cnt_next  = burst_remaining(HBURST, INCR_MAX_BEATS);
         end
         HTRANS_SEQ: begin
            // Penultimate beat, or an undefined-length burst the owner is abandoning.
            arb_point = (cnt == CNT_W'(2)) ||
                        ((cnt <= CNT_W'(1)) && !HBUSREQ[gnt_idx]);
            cnt_next  = (cnt == '0) ? '0 : cnt - CNT_W'(1);
         end
         default: ; // BUSY: hold the count, never arbitrate
      endcase
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         cnt       <= '0;
         rr_ptr    <= DEF_IDX;
         gnt_idx   <= DEF_IDX;
         HGRANT    <= DEF_GRANT;
         HMASTER   <= DEF_IDX;
         HMASTLOCK <= 1'b0;
      end else if (HREADY) begin
         // NOTE: non-blocking assignments so every register samples pre-edge values of the others.
         cnt       <= cnt_next;
         HMASTER   <= gnt_idx;
         HMASTLOCK <= HLOCK[gnt_idx];
         if (arb_point && !HLOCK[gnt_idx]) begin
            gnt_idx <= winner;
            HGRANT  <= N_MASTER'(1) << winner;
            if (winner_from_req) rr_ptr <= winner;
         end
      end
   end

endmodule
